// File: rtl/nv_ram_rws_rd_stream_if.sv
// Command and stream bundle for the nv_ram_rws read engine.
// master = command source / stream sink, slave = engine.
interface nv_ram_rws_rd_stream_if #(
  parameter int AW = 5,
  parameter int DW = 128
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/nv_ram_rws_rd_stream.sv
// Burst read engine for nv_ram_rws RAMs (1-cycle, unheld dout).
// Reads are issued only against free buffer credit, so no word is lost.
module nv_ram_rws_rd_stream #(
  parameter int AW    = 5,
  parameter int DW    = 128,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  nv_ram_rws_rd_stream_if.slave bus,
  output logic [AW-1:0]         ram_ra,
  output logic                  ram_re,
  input  logic [DW-1:0]         ram_dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          infl_q, infl_d;
  logic          ilast_q, ilast_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] last_q;

  logic          push;
  logic          pop;
  logic [CW:0]   need;

  assign push = infl_q;
  assign pop  = bus.out_valid & bus.out_ready;

  // Slots committed after this edge: buffered + returning - leaving
  assign need = {1'b0, cnt_q}
              + (CW+1)'(infl_q)
              - (CW+1)'(pop);

  assign ram_ra = addr_q;
  assign ram_re = ~rst
                & (state_q == RUN)
                & (need < DEPTH_C);

  assign bus.cmd_ready = ~rst & (state_q == IDLE);
  assign bus.out_valid = ~rst & (cnt_q != '0);
  assign bus.out_data  = data_q[rd_ptr_q];
  assign bus.out_last  = bus.out_valid
                       & last_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.cmd_valid & bus.cmd_ready) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        if (ram_re) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == '0) state_d = DRAIN;
        end
      end
      (state_q == DRAIN): begin
        if (pop & bus.out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    infl_d   = ram_re;
    ilast_d  = ram_re & (rem_q == '0);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      infl_q   <= 1'b0;
      ilast_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      infl_q   <= infl_d;
      ilast_q  <= ilast_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // RAM dout is only valid this one cycle; capture it unconditionally
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= ram_dout;
      last_q[wr_ptr_q] <= ilast_q;
    end
  end

endmodule

// File: tb/tb_nv_ram_rws_rd_stream.sv
// Bench for nv_ram_rws_rd_stream: RAM model plus a beat scoreboard
// built from the burst rules (addr+i mod 2^AW, last on final beat).
module tb_nv_ram_rws_rd_stream;

  localparam int AW    = 5;
  localparam int DW    = 128;
  localparam int DEPTH = 2;
  localparam int N     = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic [DW-1:0] ram_dout;

  nv_ram_rws_rd_stream_if #(.AW(AW), .DW(DW)) bus ();

  nv_ram_rws_rd_stream #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_ra   (ram_ra),
    .ram_re   (ram_re),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // RAM: registered read address, write-first, dout not held
  logic [DW-1:0] mem [N];
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra_q;
  logic          re_q;

  always @(posedge clk) begin
    if (we) mem[wa] <= wd;
    re_q <= ram_re;
    if (ram_re) ra_q <= ram_ra;
  end

  assign ram_dout = re_q ? mem[ra_q] : ~mem[ra_q];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic [DW-1:0] ref_mem [N];
  beat_t         exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            issued = 0;
  int            popped = 0;
  int            cyc_n  = 0;
  int            rdy_mode = 0;
  bit            stall_prev = 0;
  logic [DW-1:0] stall_data;
  bit            coll_arm = 0;
  bit            saw_last = 0;
  bit            accepted = 0;
  logic [DW-1:0] coll_val;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: entered and left at a negedge
  task automatic cyc();
    beat_t b;
    we = 1'b0;
    if (rdy_mode == 1)
      bus.out_ready = (cyc_n % 4 == 0) || (cyc_n % 4 == 3);
    else if (rdy_mode == 2)
      bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    if (coll_arm && ram_re && ram_ra == AW'(4)) begin
      we = 1'b1;
      wa = AW'(4);
      wd = coll_val;
      ref_mem[4] = coll_val;
      coll_arm = 0;
    end
    if (rst) begin
      exp_q.delete();
      issued = 0;
      popped = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk1("hold_valid", bus.out_valid, 1'b1);
        chkd("hold_data", bus.out_data, stall_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk1("spurious_beat", bus.out_valid, 1'b0);
        end else begin
          b = exp_q.pop_front();
          chkd("beat_data", bus.out_data, b.d);
          chk1("beat_last", bus.out_last, b.l);
        end
        popped++;
        if (bus.out_last) saw_last = 1;
      end
      if (ram_re) issued++;
      chk1("credit", (issued - popped) <= DEPTH, 1'b1);
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end
    accepted = bus.cmd_valid && bus.cmd_ready;
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic ram_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    ref_mem[a] = d;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
    beat_t b;
    logic [AW-1:0] ad;
    for (int i = 0; i <= int'(l); i++) begin
      ad  = AW'(int'(a) + i);
      b.d = (coll_arm && ad == AW'(4)) ? coll_val : ref_mem[ad];
      b.l = (i == int'(l));
      exp_q.push_back(b);
    end
    saw_last = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    accepted = 0;
    for (int k = 0; k < 50 && !accepted; k++) cyc();
    chk1("cmd_accept", accepted, 1'b1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_last(input int budget);
    for (int k = 0; k < budget && !saw_last; k++) cyc();
    chk1("burst_done", saw_last, 1'b1);
    chki("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    int cnt;
    logic [AW-1:0] ra;
    logic [AW-1:0] rl;
    rst = 1'b1;
    we = 1'b0;
    wa = '0;
    wd = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;
    coll_val = DW'(128'h1234);
    repeat (2) @(negedge clk);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk1("rst_ram_re", ram_re, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_out_last", bus.out_last, 1'b0);

    for (int i = 0; i < N; i++)
      ram_wr(AW'(i), {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 8; i++) ram_wr(AW'(i), DW'(i));
    ram_wr(AW'(5), {16{8'hA5}});

    rst = 1'b0;
    #1;
    chk1("idle_cmd_ready", bus.cmd_ready, 1'b1);

    // single beat
    send_cmd(AW'(5), AW'(0));
    chk1("re_after_accept", ram_re, 1'b1);
    chki("ra_after_accept", int'(ram_ra), 5);
    cyc();
    chk1("valid_not_early", bus.out_valid, 1'b0);
    cyc();
    chk1("single_valid", bus.out_valid, 1'b1);
    chk1("single_last", bus.out_last, 1'b1);
    chkd("single_data", bus.out_data, {16{8'hA5}});
    wait_last(10);
    chk1("ready_after_single", bus.cmd_ready, 1'b1);

    // full-rate burst
    ram_wr(AW'(5), DW'(5));
    send_cmd(AW'(0), AW'(7));
    cnt = 0;
    while (!bus.out_valid && cnt < 10) begin
      cyc();
      cnt++;
    end
    chki("first_latency", cnt, 2);
    for (int k = 0; k < 8; k++) begin
      chk1("stream_gap", bus.out_valid, 1'b1);
      cyc();
    end
    chk1("full_rate_last", saw_last, 1'b1);
    chki("full_rate_empty", exp_q.size(), 0);

    // wrap with backpressure pattern 1,0,0,1
    rdy_mode = 1;
    send_cmd(AW'(30), AW'(3));
    wait_last(60);
    rdy_mode = 0;
    bus.out_ready = 1'b1;
    chk1("ready_after_wrap", bus.cmd_ready, 1'b1);

    // long stall mid-burst
    p0 = popped;
    send_cmd(AW'(12), AW'(9));
    for (int k = 0; k < 20 && popped - p0 < 2; k++) cyc();
    bus.out_ready = 1'b0;
    repeat (20) cyc();
    chk1("stall_no_issue", ram_re, 1'b0);
    chki("stall_outstanding", issued - popped, DEPTH);
    bus.out_ready = 1'b1;
    wait_last(40);

    // reset during beat 3 of a 16-beat burst
    p0 = popped;
    send_cmd(AW'(16), AW'(15));
    for (int k = 0; k < 20 && popped - p0 < 3; k++) cyc();
    chk1("beat3_presented", bus.out_valid, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk1("post_rst_valid", bus.out_valid, 1'b0);
    chk1("post_rst_re", ram_re, 1'b0);
    chk1("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
    repeat (4) cyc();
    send_cmd(AW'(10), AW'(1));
    wait_last(20);

    // write collision on the read of address 4
    coll_arm = 1;
    send_cmd(AW'(2), AW'(5));
    wait_last(30);
    chk1("coll_fired", coll_arm, 1'b0);

    // random bursts, random backpressure, first one maximal
    rdy_mode = 2;
    for (int it = 0; it < 6; it++) begin
      ra = AW'($urandom);
      rl = (it == 0) ? AW'(N - 1) : AW'($urandom_range(0, N - 1));
      send_cmd(ra, rl);
      wait_last(400);
    end
    rdy_mode = 0;
    bus.out_ready = 1'b1;
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
